ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte (for example LED set 0xED, echo 0xEE, reset 0xFF) to the keyboard over the shared PS2_CLK/PS2_DAT open-drain lines.
- It is the transmit counterpart of the keyboard scan-code receive path. It sits beside key_inputs under the top level.
- It exposes a valid/ready command port and a tx_active flag. The receive path uses tx_active to ignore line activity while a transmit is in progress.

Parameters:
- INHIBIT_CYCLES, 5000: cycles the host holds clock low before the request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles allowed between consecutive device falling clock edges, counted from request-to-send (15 ms).
- CNT_W, 20: width of the shared cycle counter. It must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- CLOCK_50, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: command byte offered.
- cmd_data, in, 8: command byte.
- cmd_ready, out, 1: high only in IDLE. A byte is accepted on a cycle where cmd_valid && cmd_ready.
- tx_active, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when a transfer completes normally.
- ack_ok, out, 1: valid when done pulses. 1 means the device drove the ack bit low.
- err, out, 1: one-cycle pulse on timeout abort.
- ps2_clk_in, in, 1: raw PS2_CLK line.
- ps2_dat_in, in, 1: raw PS2_DAT line.
- ps2_clk_oe, out, 1: 1 means drive PS2_CLK low. Top level drives 1'b0 when oe is set, 1'bz otherwise.
- ps2_dat_oe, out, 1: 1 means drive PS2_DAT low. Same top-level tie-off.

Behaviour:
- Reset:
  - state=IDLE; clk_oe=0, dat_oe=0, done=0, err=0, ack_ok=0.
  - cmd_ready is forced 0 while reset is high, and reads 1 on the first cycle after release.
  - Reset mid-transfer releases both lines on the next clock edge. No done or err pulse is produced.
- Inputs: ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer. A falling edge (fe) is the synced previous value 1 and current value 0. fe is one cycle wide.
- Accept: on a cycle where cmd_valid && cmd_ready, latch the byte and compute parity = ~^cmd_data (odd parity). Then go to INHIBIT. cmd_valid in any other state is ignored.
- IDLE: both oe=0.
- INHIBIT:
  - clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles.
  - Then go to RTS with dat_oe=1 (start bit 0) set on the same edge that clears clk_oe.
  - Reset the timeout counter.
- RTS: clk_oe=0, dat_oe=1. Wait for fe, then go to SHIFT with bit_idx=1.
- SHIFT: on each fe, with bit_idx counting 1..11:
  - idx 1-8: dat_oe = ~cmd_data[idx-1] (LSB first).
  - idx 9: dat_oe = ~parity.
  - idx 10: dat_oe = 0 (stop bit, released).
  - idx 11: ack_ok <= ~dat_sync. Then go to WAIT_IDLE.
- Timeout: in RTS and SHIFT, the counter increments every cycle and clears on fe. On reaching TIMEOUT_CYCLES:
  - release both lines;
  - pulse err;
  - ack_ok=0;
  - go to IDLE.
- WAIT_IDLE:
  - Leave when synced clk and dat are both 1. The same TIMEOUT rule applies.
  - On exit, pulse done and go to IDLE. cmd_ready rises on the cycle after done.
- The FSM never drives both lines low except during INHIBIT. dat_oe is changed only on fe, or on the INHIBIT→RTS transition.
- done and err are never asserted in the same cycle.

Decomposition:
- Package ps2_pkg:
  - tx state enum: IDLE, INHIBIT, RTS, SHIFT, WAIT_IDLE;
  - constants CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF, RSP_ACK=8'hFA.
- Sub-module ps2_line_sync:
  - 2-flop synchronizer plus falling-edge detect for one line;
  - instantiated twice here and reused by the receive path.

Test Plan:
Benches run with INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, and a device model that clocks at 40-cycle period.
1. Send 0xED → clk_oe high for exactly 20 cycles → serial bits 0,1,0,1,1,0,1,1,1,1(parity),1(stop) → model acks low → done pulses with ack_ok=1, cmd_ready=1 the next cycle.
2. Send 0x01 → data bits 1,0,0,0,0,0,0,0, parity 0 → done with ack_ok=1.
3. Send 0xFF with the model leaving data high on the ack bit → done with ack_ok=0, err=0.
4. Model never clocks after RTS → err pulses 200 cycles after entering RTS → both oe=0, tx_active=0, no done.
5. Reset asserted after the 4th fe of a transfer → both oe=0 the next cycle, no done or err; cmd_ready=1 the first cycle after reset release.
6. cmd_valid held high with 0xEE, then 0xED presented during the transfer → only 0xEE is sent. After done, 0xED is accepted in IDLE and sent with correct parity 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, well-known command bytes and
// the odd-parity helper used when framing a host-to-device byte.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    WAIT_IDLE
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status port of the PS/2 host transmitter: a valid/ready byte input
// plus the completion, acknowledge and error flags returned to the requester.
interface ps2_host_tx_if;

  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       tx_active;
  logic       done;
  logic       ack_ok;
  logic       err;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, tx_active, done, ack_ok, err
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, tx_active, done, ack_ok, err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line with a one-cycle falling-edge strobe.
// Flops reset high so an idle (pulled-up) line never produces a spurious edge.
module ps2_line_sync (
  input  logic clk,
  input  logic srst,
  input  logic line,
  output logic sync,
  output logic fe
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= line;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign sync = sync_reg;
  assign fe   = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// then shifts one odd-parity framed byte out on the device's falling clock edges.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  ps2_host_tx_if.slave  cmd,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  tx_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bit_idx_reg;
  logic [8:0]       shift_reg;
  logic             clk_oe_reg;
  logic             dat_oe_reg;
  logic             done_reg;
  logic             err_reg;
  logic             ack_ok_reg;

  logic clk_sync;
  logic clk_fe;
  logic dat_sync;
  logic unused_dat_fe;

  ps2_line_sync u_clk_sync (
    .clk  (CLOCK_50),
    .srst (reset),
    .line (ps2_clk_in),
    .sync (clk_sync),
    .fe   (clk_fe)
  );

  ps2_line_sync u_dat_sync (
    .clk  (CLOCK_50),
    .srst (reset),
    .line (ps2_dat_in),
    .sync (dat_sync),
    .fe   (unused_dat_fe)
  );

  logic cmd_ready;
  logic accept;
  logic watched;
  logic lines_idle;
  logic timeout_hit;

  // Ready is held low through the done/err pulse so a new byte lands one cycle later.
  assign cmd_ready  = (state_reg == IDLE) && !reset && !done_reg && !err_reg;
  assign accept     = cmd.cmd_valid && cmd_ready;
  assign watched    = (state_reg == RTS) || (state_reg == SHIFT) || (state_reg == WAIT_IDLE);
  assign lines_idle = clk_sync && dat_sync;
  // A device edge or a clean return to idle on the same cycle wins over the timeout.
  assign timeout_hit = watched && (cnt_reg == TIMEOUT_LAST) && !clk_fe &&
                       !((state_reg == WAIT_IDLE) && lines_idle);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      clk_oe_reg  <= 1'b0;
      dat_oe_reg  <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      ack_ok_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (timeout_hit) begin
        clk_oe_reg <= 1'b0;
        dat_oe_reg <= 1'b0;
        err_reg    <= 1'b1;
        ack_ok_reg <= 1'b0;
        state_reg  <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              shift_reg  <= {odd_parity(cmd.cmd_data), cmd.cmd_data};
              cnt_reg    <= '0;
              clk_oe_reg <= 1'b1;
              dat_oe_reg <= 1'b0;
              state_reg  <= INHIBIT;
            end
          end
          INHIBIT: begin
            // Start bit goes low on the same edge the clock is released.
            if (cnt_reg == INHIBIT_LAST) begin
              clk_oe_reg <= 1'b0;
              dat_oe_reg <= 1'b1;
              cnt_reg    <= '0;
              state_reg  <= RTS;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          RTS: begin
            if (clk_fe) begin
              cnt_reg     <= '0;
              bit_idx_reg <= 4'd1;
              state_reg   <= SHIFT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          SHIFT: begin
            if (clk_fe) begin
              cnt_reg     <= '0;
              bit_idx_reg <= bit_idx_reg + 4'd1;
              if (bit_idx_reg <= 4'd9) begin
                dat_oe_reg <= ~shift_reg[0];
                shift_reg  <= shift_reg >> 1;
              end else if (bit_idx_reg == 4'd10) begin
                dat_oe_reg <= 1'b0;
              end else begin
                ack_ok_reg <= ~dat_sync;
                state_reg  <= WAIT_IDLE;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          WAIT_IDLE: begin
            if (lines_idle) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else if (clk_fe) begin
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: begin
            clk_oe_reg <= 1'b0;
            dat_oe_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        endcase
      end
    end
  end

  assign cmd.cmd_ready = cmd_ready;
  assign cmd.tx_active = (state_reg != IDLE);
  assign cmd.done      = done_reg;
  assign cmd.ack_ok    = ack_ok_reg;
  assign cmd.err       = err_reg;
  assign ps2_clk_oe    = clk_oe_reg;
  assign ps2_dat_oe    = dat_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a 40-cycle-period PS/2 device model on wired-AND lines,
// a queue of expected done/err outcomes, and a monitor that pops on each pulse.
module tb_ps2_host_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic dev_clk;
  logic dev_dat;
  logic clk_oe;
  logic dat_oe;
  logic clk_line;
  logic dat_line;

  assign clk_line = dev_clk & ~clk_oe;
  assign dat_line = dev_dat & ~dat_oe;

  ps2_host_tx_if cmd_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .TIMEOUT_CYCLES (200),
    .CNT_W          (20)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (clk_oe),
    .ps2_dat_oe (dat_oe)
  );

  typedef struct packed {
    logic is_err;
    logic ack;
  } exp_t;

  exp_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected outcome per done/err pulse.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) check("ready_after_done", cmd_if.cmd_ready, 1);
        if (cmd_if.done || cmd_if.err) begin
          check("done_err_exclusive", int'(cmd_if.done & cmd_if.err), 0);
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_pulse: done=%0d err=%0d, expected no pulse",
                     cmd_if.done, cmd_if.err);
          end else begin
            e = exp_q.pop_front();
            check("outcome_is_err", cmd_if.err, e.is_err);
            if (!e.is_err) check("ack_ok", cmd_if.ack_ok, e.ack);
            check("ready_low_in_pulse", cmd_if.cmd_ready, 0);
          end
        end
        if (clk_oe && dat_oe) begin
          tests_run++;
          tests_failed++;
          $display("FAIL both_lines_low: clk_oe=1 dat_oe=1, expected at most one");
        end
        prev_done = cmd_if.done;
      end
    end
  end

  task automatic offer(input logic [7:0] b, input bit hold);
    int t;
    @(negedge clk);
    cmd_if.cmd_data  = b;
    cmd_if.cmd_valid = 1'b1;
    t = 0;
    while (!cmd_if.cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("offer_ready", cmd_if.cmd_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) cmd_if.cmd_valid = 1'b0;
  endtask

  // mode 0: ack low, 1: ack left high, 2: never clocks, 3: reset after 4th falling edge
  task automatic dev_transfer(input logic [10:0] exp_frame, input int mode);
    int t;
    int hi;
    int n;
    logic [10:0] got;
    got = '0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!clk_oe && t < 100);
    hi = 0;
    while (clk_oe && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("inhibit_len", hi, 20);
    check("rts_dat_oe", dat_oe, 1);
    check("rts_tx_active", cmd_if.tx_active, 1);
    check("rts_ready_low", cmd_if.cmd_ready, 0);
    if (mode == 2) begin
      n = 0;
      while (!cmd_if.err && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", n, 200);
      check("timeout_clk_oe", clk_oe, 0);
      check("timeout_dat_oe", dat_oe, 0);
      check("timeout_tx_active", cmd_if.tx_active, 0);
      return;
    end
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 12; i++) begin
      dev_clk = 1'b0;
      if (mode == 3 && i == 4) begin
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_clk_oe", clk_oe, 0);
        check("rst_mid_dat_oe", dat_oe, 0);
        check("rst_mid_done", cmd_if.done, 0);
        check("rst_mid_err", cmd_if.err, 0);
        check("rst_mid_ready", cmd_if.cmd_ready, 0);
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        reset   = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_release", cmd_if.cmd_ready, 1);
        check("rst_mid_tx_active", cmd_if.tx_active, 0);
        return;
      end
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 11) got[i-1] = dat_line;
      if (i == 11 && mode == 0) dev_dat = 1'b0;
      if (i == 12) dev_dat = 1'b1;
      if (i < 12) repeat (20) @(negedge clk);
    end
    check("frame", got, exp_frame);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (cmd_if.tx_active && t < 200);
    check("tx_returns_idle", cmd_if.tx_active, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    dev_clk          = 1'b1;
    dev_dat          = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_if.cmd_ready, 0);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_dat_oe", dat_oe, 0);
    check("rst_done", cmd_if.done, 0);
    check("rst_err", cmd_if.err, 0);
    check("rst_ack_ok", cmd_if.ack_ok, 0);
    check("rst_tx_active", cmd_if.tx_active, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_if.cmd_ready, 1);

    // 0xED: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    exp_q.push_back('{is_err: 1'b0, ack: 1'b1});
    offer(8'hED, 1'b0);
    dev_transfer(11'h7DA, 0);

    // 0x01: bits 1,0,0,0,0,0,0,0, parity 0
    exp_q.push_back('{is_err: 1'b0, ack: 1'b1});
    offer(8'h01, 1'b0);
    dev_transfer(11'h402, 0);

    // 0xFF with the device leaving data high on the ack bit
    exp_q.push_back('{is_err: 1'b0, ack: 1'b0});
    offer(8'hFF, 1'b0);
    dev_transfer(11'h7FE, 1);

    // device never clocks: timeout abort
    exp_q.push_back('{is_err: 1'b1, ack: 1'b0});
    offer(8'hEE, 1'b0);
    dev_transfer(11'h000, 2);

    // reset mid-transfer: no outcome expected
    offer(8'hED, 1'b0);
    dev_transfer(11'h000, 3);

    // valid held with 0xEE, data switched to 0xED mid-transfer
    exp_q.push_back('{is_err: 1'b0, ack: 1'b1});
    exp_q.push_back('{is_err: 1'b0, ack: 1'b1});
    offer(8'hEE, 1'b1);
    cmd_if.cmd_data = 8'hED;
    dev_transfer(11'h7DC, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    check("reaccept_tx_active", cmd_if.tx_active, 1);
    dev_transfer(11'h7DA, 0);

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
